// File: rtl/snn_out_pkg.sv
// Shared sizing for the spike return path: frame geometry and the zero-padded frame type.
package snn_out_pkg;

  function automatic int words_per_frame(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

  localparam int NUM_OUTPUT_P = 250;
  localparam int WORD_W_P     = 32;
  localparam int WPF_P        = words_per_frame(NUM_OUTPUT_P, WORD_W_P);

  typedef logic [WPF_P*WORD_W_P-1:0] spike_frame_t;

endpackage

// File: rtl/spike_frame_fifo.sv
// Frame-wide FIFO; occupancy is tracked by level so wrapped pointers never need comparing.
module spike_frame_fifo #(
  parameter int FRAME_W = 256,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic                     push,
  input  logic [FRAME_W-1:0]       push_data,
  input  logic                     pop,
  output logic [FRAME_W-1:0]       head,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so natural pointer overflow is the mod-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/spike_out_collector.sv
// Captures one spike frame per tick_ready rising edge and streams it to the host as WORD_W-bit words.
module spike_out_collector
  import snn_out_pkg::*;
#(
  parameter int NUM_OUTPUT = NUM_OUTPUT_P,
  parameter int WORD_W     = WORD_W_P,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic                    tick_ready,
  input  logic                    spike_en,
  input  logic [NUM_OUTPUT-1:0]   spike_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WORD_W-1:0]       m_data,
  output logic                    m_last,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             drop_cnt,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int WPF     = words_per_frame(NUM_OUTPUT, WORD_W);
  localparam int FRAME_W = WPF * WORD_W;
  localparam int IW      = (WPF > 1) ? $clog2(WPF) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WPF - 1);

  logic               tick_d;
  logic [IW-1:0]      word_idx;
  logic               rise, full, xfer, pop_last, capture, drop;
  logic [FRAME_W-1:0] frame_in;
  logic [FRAME_W-1:0] head;

  always_comb begin
    frame_in = '0;
    frame_in[NUM_OUTPUT-1:0] = spike_out;
  end

  // Stream handshake: a word moves on any clk edge with m_valid & m_ready; while
  // m_valid=1 and m_ready=0 the word and m_last hold, and m_valid never drops
  // until the word is taken (or reset).
  assign rise     = tick_ready & ~tick_d;
  assign full     = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign m_valid  = (level != '0);
  assign m_last   = m_valid & (word_idx == LAST_IDX);
  assign xfer     = m_valid & m_ready;
  assign pop_last = xfer & (word_idx == LAST_IDX);
  // A pop of the last word frees a slot in the same cycle, so a full FIFO still captures.
  assign capture  = rise & spike_en & (~full | pop_last);
  assign drop     = rise & spike_en & full & ~pop_last;
  assign m_data   = head[int'(word_idx)*WORD_W +: WORD_W];

  spike_frame_fifo #(
    .FRAME_W (FRAME_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .push      (capture),
    .push_data (frame_in),
    .pop       (pop_last),
    .head      (head),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      tick_d    <= 1'b0;
      word_idx  <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      tick_d <= tick_ready;
      if (xfer) word_idx <= pop_last ? '0 : word_idx + IW'(1);
      if (capture) frame_cnt <= frame_cnt + 16'd1;
      if (drop) begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_out_collector.sv
// Scoreboard bench for spike_out_collector: expected words queued at capture, checked as they stream out.
module tb_spike_out_collector;
  import snn_out_pkg::*;

  localparam int NO = 250;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          tick_ready = 1'b0;
  logic          spike_en = 1'b0;
  logic [NO-1:0] spike_out = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [WW-1:0] m_data;
  logic          m_last;
  logic [15:0]   frame_cnt;
  logic [15:0]   drop_cnt;
  logic          overflow;
  logic [2:0]    level;

  logic [WW:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spike_out_collector #(.NUM_OUTPUT(NO), .WORD_W(WW), .DEPTH(4)) dut (
    .clk(clk), .sys_rst(sys_rst), .tick_ready(tick_ready), .spike_en(spike_en),
    .spike_out(spike_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .level(level)
  );

  task automatic monitor();
    logic [WW:0] e;
    forever begin
      @(negedge clk);
      if (!sys_rst && m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got last=%b data=%h, required no word", m_last, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            errors++;
            $display("FAIL stream_word: got last=%b data=%h, required last=%b data=%h",
                     m_last, m_data, e[WW], e[WW-1:0]);
          end
        end
      end
    end
  endtask

  function automatic logic [NO-1:0] rand_frame();
    spike_frame_t t;
    for (int i = 0; i < WPF_P; i++) t[i*WW +: WW] = $urandom;
    return t[NO-1:0];
  endfunction

  task automatic push_frame(input logic [NO-1:0] v);
    spike_frame_t p;
    p = {{(WPF_P*WW-NO){1'b0}}, v};
    for (int i = 0; i < WPF_P; i++) exp_q.push_back({(i == WPF_P-1), p[i*WW +: WW]});
  endtask

  // Called and returns at posedge+1 with tick_ready low.
  task automatic pulse(input logic [NO-1:0] v, input logic en);
    spike_out = v; spike_en = en; tick_ready = 1'b1;
    @(posedge clk); #1;
    tick_ready = 1'b0; spike_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; m_ready = 1'b0; tick_ready = 1'b0; spike_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words pending, required 0", name, exp_q.size());
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_val("reset_m_valid", 16'(m_valid), 16'd0);
    check_val("reset_m_last", 16'(m_last), 16'd0);
    check_val("reset_level", 16'(level), 16'd0);
    check_val("reset_frame_cnt", frame_cnt, 16'd0);
    check_val("reset_drop_cnt", drop_cnt, 16'd0);
    check_val("reset_overflow", 16'(overflow), 16'd0);
  endtask

  task automatic test_single_frame();
    logic [NO-1:0] v;
    do_reset();
    v = '0; v[0] = 1'b1; v[31] = 1'b1; v[32] = 1'b1; v[249] = 1'b1;
    exp_q.push_back({1'b0, 32'h8000_0001});
    exp_q.push_back({1'b0, 32'h0000_0001});
    for (int i = 2; i < 7; i++) exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b1, 32'h0200_0000});
    m_ready = 1'b1;
    spike_out = v; spike_en = 1'b1; tick_ready = 1'b1;
    @(posedge clk); #1;
    tick_ready = 1'b0; spike_en = 1'b0;
    @(negedge clk);
    check_val("single_latency_valid", 16'(m_valid), 16'd1);
    wait_drain("single");
    check_val("single_frame_cnt", frame_cnt, 16'd1);
    check_val("single_idle_valid", 16'(m_valid), 16'd0);
  endtask

  task automatic test_gating();
    logic [NO-1:0] v;
    do_reset();
    m_ready = 1'b1;
    spike_out = rand_frame(); spike_en = 1'b0; tick_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 tick_ready = 1'b0;
    @(posedge clk); #1;
    v = rand_frame();
    push_frame(v);
    spike_out = v; spike_en = 1'b1; tick_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 tick_ready = 1'b0; spike_en = 1'b0;
    wait_drain("gating");
    check_val("gating_frame_cnt", frame_cnt, 16'd1);
    check_val("gating_drop_cnt", drop_cnt, 16'd0);
  endtask

  task automatic test_backpressure();
    logic [NO-1:0] v;
    int cyc;
    do_reset();
    v = rand_frame();
    push_frame(v);
    pulse(v, 1'b1);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (!m_valid || m_data !== exp_q[0][WW-1:0] || m_last !== exp_q[0][WW]) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b last=%b data=%h, required valid=1 last=%b data=%h",
                 m_valid, m_last, m_data, exp_q[0][WW], exp_q[0][WW-1:0]);
      end
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1 m_ready = ~m_ready;
      cyc++;
    end
    m_ready = 1'b0;
    wait_drain("backpressure");
    check_val("bp_idle_valid", 16'(m_valid), 16'd0);
    check_val("bp_level", 16'(level), 16'd0);
  endtask

  task automatic test_overflow();
    logic [NO-1:0] v;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v = rand_frame();
      if (i < 4) push_frame(v);
      pulse(v, 1'b1);
    end
    @(negedge clk);
    check_val("ovf_level", 16'(level), 16'd4);
    check_val("ovf_drop_cnt", drop_cnt, 16'd2);
    check_val("ovf_overflow", 16'(overflow), 16'd1);
    check_val("ovf_frame_cnt", frame_cnt, 16'd4);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain("overflow");
    check_val("ovf_sticky", 16'(overflow), 16'd1);
    check_val("ovf_drained_level", 16'(level), 16'd0);
  endtask

  task automatic test_full_simultaneous();
    logic [NO-1:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = rand_frame();
      push_frame(v);
      pulse(v, 1'b1);
    end
    m_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    v = rand_frame();
    push_frame(v);
    spike_out = v; spike_en = 1'b1; tick_ready = 1'b1;
    @(posedge clk); #1;
    tick_ready = 1'b0; spike_en = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check_val("simul_level", 16'(level), 16'd4);
    check_val("simul_drop_cnt", drop_cnt, 16'd0);
    check_val("simul_frame_cnt", frame_cnt, 16'd5);
    check_val("simul_overflow", 16'(overflow), 16'd0);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain("simul");
  endtask

  task automatic test_reset_mid_frame();
    logic [NO-1:0] v;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      v = rand_frame();
      push_frame(v);
      pulse(v, 1'b1);
    end
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b0; sys_rst = 1'b1;
    @(posedge clk); #1 sys_rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_val("midrst_m_valid", 16'(m_valid), 16'd0);
    check_val("midrst_level", 16'(level), 16'd0);
    check_val("midrst_frame_cnt", frame_cnt, 16'd0);
    check_val("midrst_drop_cnt", drop_cnt, 16'd0);
    @(posedge clk); #1 m_ready = 1'(($urandom_range(0, 1)) | 1);
    v = rand_frame();
    push_frame(v);
    pulse(v, 1'b1);
    wait_drain("midrst");
    check_val("midrst_frame_cnt_after", frame_cnt, 16'd1);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_frame();
    test_gating();
    test_backpressure();
    test_overflow();
    test_full_simultaneous();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
